// File: rtl/hbridge_pkg.sv
// Shared types and sizing helpers for the multi-channel H-bridge controller.
// Used by hbridge_channel and hbridge_multi_ctrl.
package hbridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_OFF_WAIT = 3'd2,
      ST_SWITCH   = 3'd3,
      ST_ON_WAIT  = 3'd4
   } ch_state_e;

   // Width of a down-counter that is loaded with (n - 1) and runs to zero.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One H-bridge channel: direction/dead-time FSM, registered EN, SA synchroniser and
// edge counter. Optional stall timer enabled by macro HBRIDGE_STALL_DETECT_EN.
//
// state    | meaning
// IDLE     | bridge off, waiting for enable
// RUN      | EN follows PWM, watching for direction change
// OFF_WAIT | EN forced low for DEADTIME clk before DIR changes
// SWITCH   | DIR updated to the requested direction (1 clk)
// ON_WAIT  | EN forced low for DEADTIME clk after DIR changed
module hbridge_channel
   import hbridge_pkg::*;
#(
   parameter int unsigned DEADTIME  = 64,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned STALL_CYC = 1 << 20
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable_i,
   input  logic             dir_req_i,
   input  logic             pwm_i,
   input  logic             duty_nz_i,
   input  logic             sa_i,
   input  logic             count_clr_i,
   input  logic             fault_clr_i,
   output logic             hb_en_o,
   output logic             hb_dir_o,
   output logic             busy_o,
   output logic             stall_fault_o,
   output logic [CNT_W-1:0] edge_count_o
);

   localparam int unsigned     DT_W    = cnt_width(DEADTIME);
   localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME - 1);

   ch_state_e        state_q, state_d;
   logic [DT_W-1:0]  dt_q, dt_d;
   logic             dir_q, dir_d;
   logic             en_q, en_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             sa_meta_q, sa_sync_q, sa_prev_q;
   logic             sa_rise;
   logic             fault_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sa_meta_q <= 1'b0;
         sa_sync_q <= 1'b0;
         sa_prev_q <= 1'b0;
      end else begin
         sa_meta_q <= sa_i;
         sa_sync_q <= sa_meta_q;
         sa_prev_q <= sa_sync_q;
      end
   end

   assign sa_rise = sa_sync_q & ~sa_prev_q;

   // Clear has priority over a coincident edge.
   always_comb begin
      count_d = count_q;
      if (count_clr_i) begin
         count_d = '0;
      end else if (sa_rise) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

`ifdef HBRIDGE_STALL_DETECT_EN
   localparam int unsigned     ST_W    = cnt_width(STALL_CYC);
   localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STALL_CYC - 1);

   logic [ST_W-1:0] stall_q, stall_d;
   logic            fault_q;
   logic            stall_hit;

   always_comb begin
      stall_d   = ST_LOAD;
      stall_hit = 1'b0;
      if ((state_q == ST_RUN) && duty_nz_i && !sa_rise) begin
         if (stall_q == '0) begin
            stall_hit = 1'b1;
         end else begin
            stall_d = stall_q - 1'b1;
         end
      end
   end

   assign fault_d = fault_clr_i ? 1'b0 : (fault_q | stall_hit);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_q <= ST_LOAD;
         fault_q <= 1'b0;
      end else begin
         stall_q <= stall_d;
         fault_q <= fault_d;
      end
   end

   assign stall_fault_o = fault_q;
`else
   logic [31:0] unused_stall;

   assign fault_d       = 1'b0;
   assign stall_fault_o = 1'b0;
   assign unused_stall  = 32'(STALL_CYC) ^ {30'd0, fault_clr_i, duty_nz_i};
`endif

   always_comb begin
      state_d = state_q;
      dt_d    = dt_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               if (dir_req_i != dir_q) begin
                  state_d = ST_OFF_WAIT;
                  dt_d    = DT_LOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!enable_i) begin
               state_d = ST_IDLE;
            end else if (dir_req_i != dir_q) begin
               state_d = ST_OFF_WAIT;
               dt_d    = DT_LOAD;
            end
         end
         ST_OFF_WAIT: begin
            if (dt_q == '0) begin
               state_d = ST_SWITCH;
            end else begin
               dt_d = dt_q - 1'b1;
            end
         end
         ST_SWITCH: begin
            dir_d   = dir_req_i;
            state_d = ST_ON_WAIT;
            dt_d    = DT_LOAD;
         end
         ST_ON_WAIT: begin
            if (dt_q == '0) begin
               state_d = enable_i ? ST_RUN : ST_IDLE;
            end else begin
               dt_d = dt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // A latched stall holds the bridge off regardless of enable.
      if (fault_d) begin
         state_d = ST_IDLE;
      end
      en_d = (state_d == ST_RUN) & pwm_i;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         dt_q    <= '0;
         dir_q   <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dt_q    <= dt_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
      end
   end

   assign hb_en_o      = en_q;
   assign hb_dir_o     = dir_q;
   assign busy_o       = (state_q == ST_OFF_WAIT) || (state_q == ST_SWITCH) ||
                         (state_q == ST_ON_WAIT);
   assign edge_count_o = count_q;

endmodule

// File: rtl/hbridge_multi_ctrl.sv
// NUM_CH-channel H-bridge controller: shared PWM prescaler/counter plus one
// hbridge_channel per bridge. Stall detection enabled by macro HBRIDGE_STALL_DETECT_EN.
module hbridge_multi_ctrl
   import hbridge_pkg::*;
#(
   parameter int unsigned NUM_CH    = 2,
   parameter int unsigned PWM_W     = 8,
   parameter int unsigned PRESCALE  = 4,
   parameter int unsigned DEADTIME  = 64,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned STALL_CYC = 1 << 20
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH*PWM_W-1:0] duty,
   input  logic [NUM_CH-1:0]       dir_req,
   output logic [NUM_CH-1:0]       hb_en,
   output logic [NUM_CH-1:0]       hb_dir,
   input  logic [NUM_CH-1:0]       sa_in,
   input  logic [NUM_CH-1:0]       count_clr,
   output logic [NUM_CH*CNT_W-1:0] edge_count,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       stall_fault,
   input  logic [NUM_CH-1:0]       fault_clr
);

   localparam int unsigned     PS_W    = cnt_width(PRESCALE);
   localparam logic [PS_W-1:0] PS_LOAD = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]  presc_q;
   logic [PWM_W-1:0] pwm_cnt_q;
   logic             pwm_tick;
   logic             pwm_wrap;

   assign pwm_tick = (presc_q == '0);
   assign pwm_wrap = pwm_tick && (pwm_cnt_q == '1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         presc_q   <= PS_LOAD;
         pwm_cnt_q <= '0;
      end else begin
         presc_q <= pwm_tick ? PS_LOAD : presc_q - 1'b1;
         if (pwm_tick) begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [PWM_W-1:0] duty_q;

      // Duty only moves at the period boundary so a period is never truncated.
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            duty_q <= '0;
         end else if (pwm_wrap) begin
            duty_q <= duty[i*PWM_W +: PWM_W];
         end
      end

      hbridge_channel #(
         .DEADTIME  (DEADTIME),
         .CNT_W     (CNT_W),
         .STALL_CYC (STALL_CYC)
      ) u_ch (
         .clk           (clk),
         .resetn        (resetn),
         .enable_i      (enable[i]),
         .dir_req_i     (dir_req[i]),
         .pwm_i         (pwm_cnt_q < duty_q),
         .duty_nz_i     (|duty[i*PWM_W +: PWM_W]),
         .sa_i          (sa_in[i]),
         .count_clr_i   (count_clr[i]),
         .fault_clr_i   (fault_clr[i]),
         .hb_en_o       (hb_en[i]),
         .hb_dir_o      (hb_dir[i]),
         .busy_o        (busy[i]),
         .stall_fault_o (stall_fault[i]),
         .edge_count_o  (edge_count[i*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_hbridge_multi_ctrl.sv
// Directed bench for hbridge_multi_ctrl (PWM_W=8, PRESCALE=4, DEADTIME=64, CNT_W=4).
// With HBRIDGE_STALL_DETECT_EN defined only the stall sequence runs.
module tb_hbridge_multi_ctrl;

   localparam int NUM_CH    = 2;
   localparam int PWM_W     = 8;
   localparam int PRESCALE  = 4;
   localparam int DEADTIME  = 64;
   localparam int CNT_W     = 4;
   localparam int STALL_CYC = 1000;

   logic                    clk = 1'b0;
   logic                    resetn;
   logic [NUM_CH-1:0]       enable;
   logic [NUM_CH*PWM_W-1:0] duty;
   logic [NUM_CH-1:0]       dir_req;
   logic [NUM_CH-1:0]       hb_en;
   logic [NUM_CH-1:0]       hb_dir;
   logic [NUM_CH-1:0]       sa_in;
   logic [NUM_CH-1:0]       count_clr;
   logic [NUM_CH*CNT_W-1:0] edge_count;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       stall_fault;
   logic [NUM_CH-1:0]       fault_clr;

   int checks = 0;
   int errors = 0;

   hbridge_multi_ctrl #(
      .NUM_CH    (NUM_CH),
      .PWM_W     (PWM_W),
      .PRESCALE  (PRESCALE),
      .DEADTIME  (DEADTIME),
      .CNT_W     (CNT_W),
      .STALL_CYC (STALL_CYC)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .enable      (enable),
      .duty        (duty),
      .dir_req     (dir_req),
      .hb_en       (hb_en),
      .hb_dir      (hb_dir),
      .sa_in       (sa_in),
      .count_clr   (count_clr),
      .edge_count  (edge_count),
      .busy        (busy),
      .stall_fault (stall_fault),
      .fault_clr   (fault_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic count_high(input int ch, input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (hb_en[ch]) c++;
      end
   endtask

   task automatic sa_pulses(input int ch, input int n);
      repeat (n) begin
         sa_in[ch] = 1'b1;
         #23;
         sa_in[ch] = 1'b0;
         #27;
      end
   endtask

   initial begin
      int c;
      int busy_cycles;
      int en_during;
      int dir_at;
      int en_k1;
      bit found;

      resetn    = 1'b0;
      enable    = '0;
      duty      = '0;
      dir_req   = '0;
      sa_in     = '0;
      count_clr = '0;
      fault_clr = '0;
      #23;
      chk("rst_hb_en", hb_en, 0);
      chk("rst_hb_dir", hb_dir, 0);
      chk("rst_busy", busy, 0);
      chk("rst_edge_count", edge_count, 0);
      chk("rst_stall", stall_fault, 0);

`ifdef HBRIDGE_STALL_DETECT_EN
      // RUN entered at the first edge after release; fault latches STALL_CYC clk later.
      @(negedge clk);
      resetn = 1'b1;
      enable[0] = 1'b1;
      duty[7:0] = 8'd128;
      repeat (995) @(negedge clk);
      chk("stall_not_yet", stall_fault[0], 0);
      repeat (10) @(negedge clk);
      chk("stall_set", stall_fault[0], 1);
      chk("stall_en_off", hb_en[0], 0);
      count_high(0, 50, c);
      chk("stall_en_held_off", c, 0);
      fault_clr[0] = 1'b1;
      @(negedge clk);
      fault_clr[0] = 1'b0;
      @(negedge clk);
      chk("stall_cleared", stall_fault[0], 0);
      count_high(0, 900, c);
      chk("stall_restart_runs", (c != 0), 1);
`else
      // Test 1: duty captured only at wrap, so the first period stays low.
      @(negedge clk);
      resetn = 1'b1;
      enable[0] = 1'b1;
      duty[7:0] = 8'd64;
      count_high(0, 1000, c);
      chk("first_period_low", c, 0);
      cyc(100);
      count_high(0, 1024, c);
      chk("duty64_high", c, 256);
      chk("run_dir0", hb_dir[0], 0);
      chk("run_busy0", busy[0], 0);

      // Test 2: reversal; OFF_WAIT 64 + SWITCH 1 + ON_WAIT 64 = 129 busy clk.
      @(negedge clk);
      dir_req[0] = 1'b1;
      busy_cycles = 0;
      en_during = 0;
      dir_at = -1;
      en_k1 = -1;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 1) en_k1 = int'(hb_en[0]);
         if (busy[0]) busy_cycles++;
         if (busy[0] && hb_en[0]) en_during++;
         if (dir_at < 0 && hb_dir[0]) dir_at = k;
      end
      chk("rev_en_off_1clk", en_k1, 0);
      chk("rev_busy_len", busy_cycles, 129);
      chk("rev_en_in_deadtime", en_during, 0);
      chk("rev_dir_switch_clk", dir_at, 66);
      count_high(0, 1024, c);
      chk("rev_resume_duty64", c, 256);

      // Test 3: mid-period duty change waits for the next wrap.
      found = 1'b0;
      for (int k = 0; k < 1100 && !found; k++) begin
         @(negedge clk);
         if (!hb_en[0]) found = 1'b1;
      end
      chk("sync_en_low_seen", found, 1);
      found = 1'b0;
      for (int k = 0; k < 1100 && !found; k++) begin
         @(negedge clk);
         if (hb_en[0]) found = 1'b1;
      end
      chk("sync_en_rise_seen", found, 1);
      cyc(300);
      @(negedge clk);
      duty[7:0] = 8'd128;
      count_high(0, 700, c);
      chk("midperiod_no_effect", c, 0);
      cyc(30);
      count_high(0, 1024, c);
      chk("duty128_high", c, 512);
      duty[7:0] = 8'd0;
      cyc(1100);
      count_high(0, 1024, c);
      chk("duty0_high", c, 0);
      duty[7:0] = 8'd255;
      cyc(1100);
      count_high(0, 1024, c);
      chk("duty255_high", c, 1020);

      // Test 4: edge counting, clear priority and CNT_W=4 wrap.
      #3;
      sa_pulses(0, 10);
      cyc(5);
      @(negedge clk);
      chk("sa_10_edges", edge_count[3:0], 10);
      chk("sa_ch1_idle", edge_count[7:4], 0);
      @(negedge clk);
      sa_in[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 count_clr[0] = 1'b1;
      @(posedge clk);
      #1 count_clr[0] = 1'b0;
      sa_in[0] = 1'b0;
      cyc(5);
      @(negedge clk);
      chk("clr_wins_edge", edge_count[3:0], 0);
      #7;
      sa_pulses(0, 17);
      cyc(5);
      @(negedge clk);
      chk("sa_17_wraps", edge_count[3:0], 1);

      // Test 5: async reset in the middle of OFF_WAIT.
      @(negedge clk);
      dir_req[0] = 1'b0;
      cyc(10);
      @(negedge clk);
      chk("offwait_busy", busy[0], 1);
      chk("offwait_dir_held", hb_dir[0], 1);
      #2 resetn = 1'b0;
      #1;
      chk("arst_hb_en", hb_en, 0);
      chk("arst_hb_dir", hb_dir, 0);
      chk("arst_busy", busy, 0);
      chk("arst_edge_count", edge_count, 0);
      enable[0] = 1'b0;
      duty[7:0] = 8'd128;
      @(negedge clk);
      resetn = 1'b1;
      count_high(0, 20, c);
      chk("idle_after_rst_en", c, 0);
      chk("idle_after_rst_busy", busy[0], 0);
      enable[0] = 1'b1;
      cyc(5);
      @(negedge clk);
      chk("run_direct_no_busy", busy[0], 0);

      // Channel 1 from IDLE with a mismatched direction goes through dead-time.
      enable[1] = 1'b1;
      dir_req[1] = 1'b1;
      duty[15:8] = 8'd32;
      cyc(2);
      @(negedge clk);
      chk("ch1_busy", busy[1], 1);
      chk("ch1_ch0_not_busy", busy[0], 0);
      cyc(140);
      @(negedge clk);
      chk("ch1_dir_set", hb_dir[1], 1);
      chk("ch1_busy_done", busy[1], 0);
      cyc(1100);
      count_high(1, 1024, c);
      chk("ch1_duty32_high", c, 128);
      count_high(0, 1024, c);
      chk("ch0_after_rst_duty128", c, 512);
      chk("no_stall_without_macro", stall_fault, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
